// File: rtl/activation_pkg.sv
// Shared types and IEEE-754 constants for the activation unit.
// The lane evaluator and the sequencing top both import this package.
package activation_pkg;

  typedef enum logic [1:0] {
    ACT_STEP     = 2'd0,
    ACT_RELU     = 2'd1,
    ACT_BIPOLAR  = 2'd2,
    ACT_IDENTITY = 2'd3
  } act_mode_t;

  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

  localparam logic [31:0] FP_ONE     = 32'h3F80_0000;
  localparam logic [31:0] FP_NEG_ONE = 32'hBF80_0000;
  localparam logic [31:0] FP_ZERO    = 32'h0000_0000;
  localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;

  typedef struct packed {
    logic [31:0] result;
    logic        is_nan;
  } lane_res_t;

  function automatic logic fp_is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

endpackage

// File: rtl/activation_lane.sv
// Combinational single-lane activation evaluator.
// Infinities follow the sign rule; NaNs are never positive.
module activation_lane
  import activation_pkg::*;
(
  input  act_mode_t   mode,
  input  logic [31:0] x,
  output lane_res_t   res
);

  logic nan;
  logic pos;

  assign nan = fp_is_nan(x);
  assign pos = !x[31] && (x[30:0] != 31'd0) && !nan;

  always_comb begin
    res.is_nan = nan;
    res.result = FP_ZERO;
    case (mode)
      ACT_STEP:    res.result = pos ? FP_ONE : FP_ZERO;
      ACT_RELU:    res.result = nan ? FP_QNAN : (pos ? x : FP_ZERO);
      ACT_BIPOLAR: res.result = pos ? FP_ONE : FP_NEG_ONE;
      default:     res.result = nan ? FP_QNAN : x;
    endcase
  end

endmodule

// File: rtl/activation_unit.sv
// Vector activation stage: latches LANES floats, evaluates one lane per cycle
// through a shared evaluator and returns the vector over the STB/BUSY handshake.
module activation_unit
  import activation_pkg::*;
#(
  parameter  int LANES = 4,
  localparam int CNT_W = $clog2(LANES) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [32*LANES-1:0] in_data,
  input  logic [1:0]          in_mode,
  input  logic                in_stb,
  output logic                in_busy,
  output logic [32*LANES-1:0] out_data,
  output logic                out_nan,
  output logic                out_stb,
  input  logic                out_busy
);

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic [LANES-1:0][31:0]  in_vec, data_q, out_q;
  act_mode_t               mode_q;
  logic [31:0]             lane_x;
  lane_res_t               lane_res;
  logic                    last;

  assign in_vec   = in_data;
  assign out_data = out_q;
  assign last     = (cnt == CNT_W'(LANES - 1));

  // Compare-based select keeps the index width independent of LANES.
  always_comb begin
    lane_x = data_q[0];
    for (int i = 0; i < LANES; i++)
      if (cnt == CNT_W'(i)) lane_x = data_q[i];
  end

  activation_lane u_lane (
    .mode (mode_q),
    .x    (lane_x),
    .res  (lane_res)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_stb) state_nxt = EVAL;
      EVAL:    if (last) state_nxt = DONE;
      DONE:    if (out_stb && !out_busy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      data_q  <= '0;
      out_q   <= '0;
      mode_q  <= ACT_STEP;
      in_busy <= 1'b0;
      out_stb <= 1'b0;
      out_nan <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_stb) begin
          data_q  <= in_vec;
          mode_q  <= act_mode_t'(in_mode);
          out_nan <= 1'b0;
          cnt     <= '0;
          in_busy <= 1'b1;
        end
        EVAL: begin
          for (int i = 0; i < LANES; i++)
            if (cnt == CNT_W'(i)) out_q[i] <= lane_res.result;
          out_nan <= out_nan | lane_res.is_nan;
          cnt     <= cnt + CNT_W'(1);
          if (last) out_stb <= 1'b1;
        end
        DONE: if (out_stb && !out_busy) begin
          out_stb <= 1'b0;
          in_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_activation_unit.sv
// Directed bench for activation_unit: a 4-lane instance and a 1-lane instance
// driven on falling edges, with hand-computed expected vectors.
module tb_activation_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [127:0] in_data4, out_data4;
  logic [1:0]   in_mode4;
  logic         in_stb4, in_busy4, out_nan4, out_stb4, out_busy4;

  logic [31:0]  in_data1, out_data1;
  logic [1:0]   in_mode1;
  logic         in_stb1, in_busy1, out_nan1, out_stb1, out_busy1;

  int checks = 0;
  int fails  = 0;

  activation_unit #(.LANES(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .in_data(in_data4), .in_mode(in_mode4), .in_stb(in_stb4), .in_busy(in_busy4),
    .out_data(out_data4), .out_nan(out_nan4), .out_stb(out_stb4), .out_busy(out_busy4)
  );

  activation_unit #(.LANES(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_data(in_data1), .in_mode(in_mode1), .in_stb(in_stb1), .in_busy(in_busy1),
    .out_data(out_data1), .out_nan(out_nan1), .out_stb(out_stb1), .out_busy(out_busy1)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Accept on the next rising edge, then scramble inputs to prove they were latched.
  task automatic start4(input logic [1:0] m, input logic [127:0] d);
    @(negedge clk);
    in_data4 = d; in_mode4 = m; in_stb4 = 1'b1;
    @(negedge clk);
    in_stb4 = 1'b0; in_data4 = {4{32'hDEAD_BEEF}}; in_mode4 = ~m;
  endtask

  task automatic wait4(input string tag);
    int lat = 0;
    while (!out_stb4 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk(tag, 128'(lat), 128'd4);
  endtask

  task automatic run4(input string tag, input logic [1:0] m, input logic [127:0] d,
                      input logic [127:0] exp_d, input logic exp_nan);
    start4(m, d);
    chk({tag, "_busy"}, 128'(in_busy4), 128'd1);
    wait4({tag, "_lat"});
    chk({tag, "_data"}, out_data4, exp_d);
    chk({tag, "_nan"}, 128'(out_nan4), 128'(exp_nan));
    @(negedge clk);
    chk({tag, "_stb_fall"}, 128'(out_stb4), 128'd0);
    chk({tag, "_busy_fall"}, 128'(in_busy4), 128'd0);
  endtask

  task automatic run1(input string tag, input logic [31:0] d, input logic [31:0] exp_d,
                      input logic exp_nan);
    int lat = 0;
    @(negedge clk);
    in_data1 = d; in_mode1 = 2'd3; in_stb1 = 1'b1;
    @(negedge clk);
    in_stb1 = 1'b0; in_data1 = 32'h0BAD_F00D; in_mode1 = 2'd0;
    while (!out_stb1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 128'(lat), 128'd1);
    chk({tag, "_data"}, 128'(out_data1), 128'(exp_d));
    chk({tag, "_nan"}, 128'(out_nan1), 128'(exp_nan));
    @(negedge clk);
    chk({tag, "_stb_fall"}, 128'(out_stb1), 128'd0);
    chk({tag, "_busy_fall"}, 128'(in_busy1), 128'd0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    in_data4 = '0; in_mode4 = '0; in_stb4 = 1'b0; out_busy4 = 1'b0;
    in_data1 = '0; in_mode1 = '0; in_stb1 = 1'b0; out_busy1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_stb4",  128'(out_stb4), 128'd0);
    chk("rst_busy4", 128'(in_busy4), 128'd0);
    chk("rst_nan4",  128'(out_nan4), 128'd0);
    chk("rst_data4", out_data4, 128'd0);
    chk("rst_stb1",  128'(out_stb1), 128'd0);
    chk("rst_data1", 128'(out_data1), 128'd0);
    rst = 1'b0;

    run4("step", 2'd0, 128'hC0000000_80000000_00000000_3F000000,
         128'h00000000_00000000_00000000_3F800000, 1'b0);
    run4("relu", 2'd1, 128'h7FC00001_FF800000_00000001_40490FDB,
         128'h7FC00000_00000000_00000001_40490FDB, 1'b1);
    run4("bip", 2'd2, 128'h7F800000_80000000_7F800001_BF800000,
         128'h3F800000_BF800000_BF800000_BF800000, 1'b1);

    // Backpressure in DONE, with a stray strobe that must be ignored.
    out_busy4 = 1'b1;
    start4(2'd3, 128'hFFC00000_80000000_7F800000_12345678);
    wait4("bp_lat");
    chk("bp_nan", 128'(out_nan4), 128'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 3) begin
        in_stb4 = 1'b1; in_data4 = '0; in_mode4 = 2'd0;
      end else begin
        in_stb4 = 1'b0;
      end
      chk("bp_hold_stb", 128'(out_stb4), 128'd1);
      chk("bp_hold_data", out_data4, 128'h7FC00000_80000000_7F800000_12345678);
      chk("bp_hold_busy", 128'(in_busy4), 128'd1);
    end
    @(negedge clk);
    in_stb4 = 1'b1; in_mode4 = 2'd0;
    in_data4 = 128'h00000001_FF800000_7F800000_80000001;
    out_busy4 = 1'b0;
    @(negedge clk);
    chk("bp_rel_stb", 128'(out_stb4), 128'd0);
    chk("bp_rel_busy", 128'(in_busy4), 128'd0);
    @(negedge clk);
    chk("bp_pend_acc", 128'(in_busy4), 128'd1);
    in_stb4 = 1'b0; in_data4 = '1; in_mode4 = 2'd3;
    wait4("pend_lat");
    chk("pend_data", out_data4, 128'h3F800000_00000000_3F800000_00000000);
    chk("pend_nan", 128'(out_nan4), 128'd0);
    @(negedge clk);
    chk("pend_stb_fall", 128'(out_stb4), 128'd0);

    // Asynchronous reset two cycles into EVAL.
    start4(2'd1, 128'h3F800000_3F800000_3F800000_3F800000);
    @(posedge clk);
    #1 chk("mid_busy", 128'(in_busy4), 128'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_stb", 128'(out_stb4), 128'd0);
    chk("mid_rst_busy", 128'(in_busy4), 128'd0);
    chk("mid_rst_data", out_data4, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    run4("post_rst", 2'd2, 128'h00000000_00800000_80800000_7FFFFFFF,
         128'hBF800000_3F800000_BF800000_BF800000, 1'b1);

    run1("id1_a", 32'h40490FDB, 32'h40490FDB, 1'b0);
    run1("id1_b", 32'hFF800001, 32'h7FC00000, 1'b1);
    run1("id1_c", 32'h80000000, 32'h80000000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/activation_unit.md
Name: activation_unit

Overview:
- Parametrised successor to the single-bit step stage in the neurosynapse datapath.
- Accepts a vector of LANES IEEE-754 single-precision values and applies a selectable activation function to every lane.
- Returns the result vector over the same STB/BUSY handshake used between the operation stages.
- Lanes are evaluated one per cycle through a shared per-lane evaluator, keeping area flat as LANES grows.

Parameters:
- LANES, 4, number of 32-bit float lanes per transaction (1..16).
- CNT_W, $clog2(LANES)+1, lane counter width (derived; not overridden).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_data  input  32*LANES  operand vector; lane i occupies bits [32*i+31:32*i].
- in_mode  input  2  activation select, sampled at accept.
- in_stb  input  1  upstream strobe; data and mode are valid.
- in_busy  output  1  registered; high while a transaction is in flight.
- out_data  output  32*LANES  result vector.
- out_nan  output  1  at least one input lane was NaN; valid while out_stb is high.
- out_stb  output  1  result valid.
- out_busy  input  1  downstream busy.

Behaviour:
- Reset (async, any state): state=IDLE, in_busy=0, out_stb=0, out_nan=0, out_data=0, lane counter=0. An in-flight transaction is discarded with no partial output.
- Modes, per lane x:
  - 0 STEP: 0x3F800000 if x>0, else 0x00000000.
  - 1 RELU: x if x>0, else 0x00000000.
  - 2 BIPOLAR: 0x3F800000 if x>0, else 0xBF800000.
  - 3 IDENTITY: x unchanged.
- Positivity rule: x>0 means sign=0, bits[30:0]!=0, and x is not NaN. +0 and -0 are not positive. Positive denormals are positive.
- NaN rule: NaN is exp=0xFF with mantissa!=0.
  - STEP gives 0x00000000; BIPOLAR gives 0xBF800000.
  - RELU and IDENTITY give canonical 0x7FC00000.
  - Every NaN lane sets out_nan.
- +/-Inf follow the sign rule; they are not NaN.
- FSM IDLE:
  - in_busy=0.
  - When in_stb=1, latch in_data and in_mode, clear out_nan, counter=0, in_busy<=1, go to EVAL.
- FSM EVAL:
  - Each cycle, write the result for lane[counter] into out_data and OR that lane's NaN flag into out_nan.
  - Increment counter each cycle.
  - On the edge that writes lane LANES-1, set out_stb<=1 and go to DONE.
- FSM DONE:
  - out_stb, out_data and out_nan are held stable.
  - On an edge with out_stb=1 and out_busy=0, set out_stb<=0 and in_busy<=0, go to IDLE.
- Latency: out_stb rises LANES cycles after the accept edge.
- Throughput: one transaction per LANES+2 cycles with no backpressure.
- in_stb seen while in_busy=1 is ignored. Upstream must hold in_stb until it sees in_busy=0 with in_stb high at an edge.
- out_busy held high keeps DONE indefinitely. No new accept occurs in DONE.
- in_mode and in_data changes after accept have no effect on the current transaction.
- out_data lanes not yet written in EVAL keep their previous values. They are only observable once out_stb=1, by which point all lanes are rewritten.
- LANES=1: EVAL lasts exactly one cycle.

Decomposition:
- activation_pkg holds:
  - enum act_mode_t {ACT_STEP=0, ACT_RELU=1, ACT_BIPOLAR=2, ACT_IDENTITY=3};
  - enum state_t {IDLE, EVAL, DONE};
  - constants FP_ONE=0x3F800000, FP_NEG_ONE=0xBF800000, FP_ZERO=0x00000000, FP_QNAN=0x7FC00000.
- Sub-module activation_lane: combinational, one 32-bit x plus mode in, 32-bit result plus is_nan out. Instanced once and muxed by the lane counter.

Test Plan:
- Reset mid-EVAL (LANES=4, assert rst two cycles after accept): out_stb=0 and in_busy=0 immediately (async). The next transaction completes normally.
- STEP, in_data={0xC0000000, 0x80000000, 0x00000000, 0x3F000000} (lane3..lane0): out_data={0,0,0,0x3F800000}, out_nan=0, out_stb rises 4 cycles after accept.
- RELU, {0x7FC00001, 0xFF800000, 0x00000001, 0x40490FDB}: out_data={0x7FC00000, 0, 0x00000001, 0x40490FDB}, out_nan=1.
- BIPOLAR, {0x7F800000, 0x80000000, 0x7F800001, 0xBF800000}: out_data={0x3F800000, 0xBF800000, 0xBF800000, 0xBF800000}, out_nan=1.
- Backpressure: hold out_busy=1 for 10 cycles in DONE. out_stb and out_data stay stable. An in_stb pulse during DONE is ignored. Release out_busy: out_stb falls next edge, in_busy falls, and a pending in_stb is accepted the following edge.
- IDENTITY back-to-back with LANES=1: three transactions, each out_stb one cycle after accept. Data passes through bit-exact, except NaN inputs, which return 0x7FC00000.
